// File: rtl/hub_pkg.sv
// hub_pkg: shared hub message format, destination field and broadcast id
package hub_pkg;
  localparam int INTERCONNECT_WIDTH = 32;
  localparam int DEST_WIDTH = 4;
  localparam int DEST_MSB = INTERCONNECT_WIDTH - 1;
  localparam logic [DEST_WIDTH-1:0] BROADCAST_ID = 4'hF;
  typedef logic [INTERCONNECT_WIDTH-1:0] hub_word_t;
  function automatic logic [DEST_WIDTH-1:0] get_dest(input hub_word_t data);
    return data[DEST_MSB -: DEST_WIDTH];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with registered pointer advanced past each winner
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         any
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, gidx;
  always_comb begin
    grant = '0;
    gidx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any = 1'b1;
        grant[k] = 1'b1;
        gidx = PW'(k);
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (advance && any) ptr <= (int'(gidx) == N - 1) ? '0 : gidx + PW'(1);
endmodule

// File: rtl/hub_child_router.sv
// hub_child_router: fans root-hub words out to children by dest, merges child words back round-robin
module hub_child_router
  import hub_pkg::*;
#(
  parameter int NUM_CHILDREN = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [INTERCONNECT_WIDTH-1:0]           upstream_fifo_in_data,
  input  logic                                    upstream_fifo_in_valid,
  output logic                                    upstream_fifo_in_ready,
  output logic [INTERCONNECT_WIDTH-1:0]           upstream_fifo_out_data,
  output logic                                    upstream_fifo_out_valid,
  input  logic                                    upstream_fifo_out_ready,
  output logic [NUM_CHILDREN*INTERCONNECT_WIDTH-1:0] downstream_fifo_out_data,
  output logic [NUM_CHILDREN-1:0]                 downstream_fifo_out_valid,
  input  logic [NUM_CHILDREN-1:0]                 downstream_fifo_out_ready,
  input  logic [NUM_CHILDREN*INTERCONNECT_WIDTH-1:0] downstream_fifo_in_data,
  input  logic [NUM_CHILDREN-1:0]                 downstream_fifo_in_valid,
  output logic [NUM_CHILDREN-1:0]                 downstream_fifo_in_ready,
  input  logic [NUM_CHILDREN-1:0]                 downstream_has_message_flying,
  input  logic [NUM_CHILDREN-1:0]                 downstream_has_odd_clusters,
  output logic                                    upstream_has_message_flying,
  output logic                                    upstream_has_odd_clusters,
  output logic                                    route_error
);
  localparam int W = INTERCONNECT_WIDTH;
  logic [DEST_WIDTH-1:0] dest;
  logic [2**DEST_WIDTH-1:0] free_x;
  logic [NUM_CHILDREN-1:0] free, load, grant;
  logic is_bc, is_uni, accept, up_free, any;
  logic [W-1:0] sel;
  assign dest = get_dest(upstream_fifo_in_data);
  assign is_bc = dest == BROADCAST_ID;
  assign is_uni = int'(dest) < NUM_CHILDREN;
  assign free = ~downstream_fifo_out_valid | downstream_fifo_out_ready;
  assign free_x = (2**DEST_WIDTH)'(free);
  assign upstream_fifo_in_ready = is_bc ? &free : is_uni ? free_x[dest] : 1'b1;
  assign accept = upstream_fifo_in_valid && upstream_fifo_in_ready;
  assign up_free = !upstream_fifo_out_valid || upstream_fifo_out_ready;
  assign downstream_fifo_in_ready = up_free ? grant : '0;
  always_comb begin
    load = '0;
    sel = '0;
    for (int c = 0; c < NUM_CHILDREN; c++) begin
      load[c] = accept && (is_bc || (is_uni && dest == DEST_WIDTH'(c)));
      if (grant[c]) sel = downstream_fifo_in_data[c*W +: W];
    end
  end
  rr_arbiter #(.N(NUM_CHILDREN)) u_arb (
    .clk(clk),
    .rst(reset),
    .req(downstream_fifo_in_valid),
    .advance(up_free),
    .grant(grant),
    .any(any)
  );
  always_ff @(posedge clk)
    if (reset) begin
      downstream_fifo_out_valid <= '0;
      downstream_fifo_out_data <= '0;
      route_error <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CHILDREN; c++)
        if (load[c]) begin
          downstream_fifo_out_valid[c] <= 1'b1;
          downstream_fifo_out_data[c*W +: W] <= upstream_fifo_in_data;
        end else if (downstream_fifo_out_ready[c]) downstream_fifo_out_valid[c] <= 1'b0;
      if (accept && !is_bc && !is_uni) route_error <= 1'b1;
    end
  always_ff @(posedge clk)
    if (reset) begin
      upstream_fifo_out_valid <= 1'b0;
      upstream_fifo_out_data <= '0;
    end else if (up_free && any) begin
      upstream_fifo_out_valid <= 1'b1;
      upstream_fifo_out_data <= sel;
    end else if (upstream_fifo_out_ready) upstream_fifo_out_valid <= 1'b0;
  always_ff @(posedge clk)
    if (reset) begin
      upstream_has_message_flying <= 1'b0;
      upstream_has_odd_clusters <= 1'b0;
    end else begin
      upstream_has_message_flying <= |downstream_has_message_flying | |downstream_fifo_out_valid |
        upstream_fifo_out_valid | upstream_fifo_in_valid | |downstream_fifo_in_valid;
      upstream_has_odd_clusters <= |downstream_has_odd_clusters;
    end
endmodule

// File: tb/tb_hub_child_router.sv
// tb_hub_child_router: directed checks of routing, broadcast, arbitration, status and reset
module tb_hub_child_router;
  logic clk = 0, reset = 1;
  logic [31:0] in_data = '0, out_data;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [63:0] dn_out_data, dn_in_data = '0;
  logic [1:0] dn_out_valid, dn_out_ready = 2'b11, dn_in_valid = '0, dn_in_ready;
  logic [1:0] dn_mf = '0, dn_odd = '0;
  logic up_mf, up_odd, route_error;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  hub_child_router #(.NUM_CHILDREN(2)) dut (
    .clk(clk),
    .reset(reset),
    .upstream_fifo_in_data(in_data),
    .upstream_fifo_in_valid(in_valid),
    .upstream_fifo_in_ready(in_ready),
    .upstream_fifo_out_data(out_data),
    .upstream_fifo_out_valid(out_valid),
    .upstream_fifo_out_ready(out_ready),
    .downstream_fifo_out_data(dn_out_data),
    .downstream_fifo_out_valid(dn_out_valid),
    .downstream_fifo_out_ready(dn_out_ready),
    .downstream_fifo_in_data(dn_in_data),
    .downstream_fifo_in_valid(dn_in_valid),
    .downstream_fifo_in_ready(dn_in_ready),
    .downstream_has_message_flying(dn_mf),
    .downstream_has_odd_clusters(dn_odd),
    .upstream_has_message_flying(up_mf),
    .upstream_has_odd_clusters(up_odd),
    .route_error(route_error)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_dn_valid", 64'(dn_out_valid), 64'h0);
    chk("rst_up_valid", 64'(out_valid), 64'h0);
    chk("rst_route_error", 64'(route_error), 64'h0);
    chk("rst_flags", 64'({up_mf, up_odd}), 64'h0);
    chk("rst_up_data", 64'(out_data), 64'h0);
    reset = 0;
    in_data = 32'h1000_00AB;
    in_valid = 1;
    #1;
    chk("uni_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 0;
    chk("uni_valid", 64'(dn_out_valid), 64'h2);
    chk("uni_data", 64'(dn_out_data[63:32]), 64'h1000_00AB);
    chk("uni_flying", 64'(up_mf), 64'h1);
    step();
    chk("uni_drain", 64'(dn_out_valid), 64'h0);
    dn_out_ready = 2'b10;
    in_data = 32'hF000_0001;
    in_valid = 1;
    #1;
    chk("bc1_ready", 64'(in_ready), 64'h1);
    step();
    in_data = 32'hF000_0002;
    #1;
    chk("bc1_valid", 64'(dn_out_valid), 64'h3);
    chk("bc1_data", 64'(dn_out_data), 64'hF000_0001_F000_0001);
    chk("bc2_blocked", 64'(in_ready), 64'h0);
    step();
    chk("bc2_no_partial", 64'(dn_out_valid), 64'h1);
    chk("bc2_hold", 64'(dn_out_data[31:0]), 64'hF000_0001);
    dn_out_ready = 2'b01;
    #1;
    chk("bc2_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 0;
    dn_out_ready = 2'b11;
    chk("bc2_valid", 64'(dn_out_valid), 64'h3);
    chk("bc2_data", 64'(dn_out_data), 64'hF000_0002_F000_0002);
    step();
    chk("bc_drain", 64'(dn_out_valid), 64'h0);
    in_data = 32'h2000_0005;
    in_valid = 1;
    #1;
    chk("bad_ready", 64'(in_ready), 64'h1);
    step();
    in_data = 32'h0000_0077;
    chk("bad_dropped", 64'(dn_out_valid), 64'h0);
    chk("bad_err", 64'(route_error), 64'h1);
    step();
    in_valid = 0;
    chk("after_valid", 64'(dn_out_valid), 64'h1);
    chk("after_data", 64'(dn_out_data[31:0]), 64'h77);
    chk("err_sticky", 64'(route_error), 64'h1);
    step();
    dn_in_data = {32'hB1B1_0001, 32'hA0A0_0000};
    dn_in_valid = 2'b11;
    #1;
    chk("rr_grant0", 64'(dn_in_ready), 64'h1);
    step();
    chk("rr_w0", 64'(out_data), 64'hA0A0_0000);
    chk("rr_grant1", 64'(dn_in_ready), 64'h2);
    step();
    chk("rr_w1", 64'(out_data), 64'hB1B1_0001);
    step();
    chk("rr_w2", 64'(out_data), 64'hA0A0_0000);
    step();
    chk("rr_w3", 64'({out_valid, out_data}), 64'h1_B1B1_0001);
    dn_in_valid = 2'b00;
    step();
    chk("rr_idle", 64'(out_valid), 64'h0);
    step();
    chk("mf_idle", 64'(up_mf), 64'h0);
    dn_mf = 2'b10;
    step();
    chk("mf_set", 64'(up_mf), 64'h1);
    dn_mf = 2'b00;
    step();
    chk("mf_clear", 64'(up_mf), 64'h0);
    dn_odd = 2'b01;
    step();
    chk("odd_set", 64'(up_odd), 64'h1);
    dn_odd = 2'b00;
    dn_out_ready = 2'b01;
    in_data = 32'h1000_0099;
    in_valid = 1;
    step();
    in_valid = 0;
    out_ready = 0;
    dn_in_valid = 2'b01;
    step();
    dn_in_valid = 2'b00;
    chk("pre_dn_valid", 64'(dn_out_valid), 64'h2);
    chk("pre_up", 64'({out_valid, out_data}), 64'h1_A0A0_0000);
    reset = 1;
    step();
    chk("mid_dn_valid", 64'(dn_out_valid), 64'h0);
    chk("mid_up_valid", 64'(out_valid), 64'h0);
    chk("mid_err", 64'(route_error), 64'h0);
    chk("mid_flags", 64'({up_mf, up_odd}), 64'h0);
    reset = 0;
    out_ready = 1;
    dn_out_ready = 2'b11;
    dn_in_valid = 2'b11;
    #1;
    chk("post_grant0", 64'(dn_in_ready), 64'h1);
    step();
    chk("post_w0", 64'(out_data), 64'hA0A0_0000);
    dn_in_valid = 2'b00;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
